// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: reset/exception vectors, instruction step
// and the next-PC source encoding used by pc_gen.
package cpu_pkg;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;
    localparam int unsigned INSTR_STEP   = 32'd4;

    typedef enum logic [2:0] {
        SEL_EXC   = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_RAS   = 3'd2,
        SEL_REDIR = 3'd3,
        SEL_SEQ   = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control/hazard-unit to PC-generator bundle. The master drives fetch
// control; the slave (pc_gen) returns the PC and RAS status.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 3
);
    logic             stall;
    logic             exc_req;
    logic             redirect_vld;
    logic [WIDTH-1:0] redirect_pc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [CNT_W-1:0] ras_cnt;
    logic             ret_miss;

    modport master (
        output stall, exc_req, redirect_vld, redirect_pc, call, ret,
        input  pc, pc_plus, ras_cnt, ret_miss
    );

    modport slave (
        input  stall, exc_req, redirect_vld, redirect_pc, call, ret,
        output pc, pc_plus, ras_cnt, ret_miss
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack. ptr_r is the next free slot, so the top
// entry is always mem[ptr_r-1]; a full push silently overwrites the oldest.
module ras_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] top_idx_s;

    assign top_idx_s = ptr_r - PTR_W'(1);
    assign top       = mem_r[top_idx_s];
    assign cnt       = cnt_r;

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[ptr_r] <= din;
        end else if (replace) begin
            mem_r[top_idx_s] <= din;
        end
    end

    // Pointer and occupancy; replace on an empty stack materialises one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= PTR_W'(0);
            cnt_r <= CNT_W'(0);
        end else if (push) begin
            ptr_r <= ptr_r + PTR_W'(1);
            if (cnt_r != CNT_W'(DEPTH)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else if (pop && (cnt_r != CNT_W'(0))) begin
            ptr_r <= top_idx_s;
            cnt_r <= cnt_r - CNT_W'(1);
        end else if (replace && (cnt_r == CNT_W'(0))) begin
            cnt_r <= CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority mux over exception, stall, RAS
// return, redirect and sequential sources, with a registered PC.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int unsigned     STEP      = INSTR_STEP,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_plus_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] ras_top_s;
    logic [CNT_W-1:0] ras_cnt_s;
    logic             ras_empty_s;
    logic             ret_miss_r;
    logic             miss_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             replace_s;
    pc_sel_e          sel_s;

    assign pc_plus_s   = pc_r + WIDTH'(STEP);
    assign ras_empty_s = (ras_cnt_s == CNT_W'(0));

    // Source selection in strict priority order.
    always_comb begin
        sel_s = SEL_SEQ;
        if (bus.exc_req) begin
            sel_s = SEL_EXC;
        end else if (bus.stall) begin
            sel_s = SEL_HOLD;
        end else if (bus.ret) begin
            sel_s = SEL_RAS;
        end else if (bus.redirect_vld) begin
            sel_s = SEL_REDIR;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next PC and RAS commands; a ret+call pair swaps the top in place.
    always_comb begin
        pc_nxt_s   = pc_plus_s;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        replace_s  = 1'b0;
        miss_nxt_s = 1'b0;
        case (sel_s)
            SEL_EXC:   pc_nxt_s = EXC_VEC;
            SEL_HOLD:  pc_nxt_s = pc_r;
            SEL_RAS: begin
                pc_nxt_s   = ras_empty_s ? pc_plus_s : ras_top_s;
                miss_nxt_s = ras_empty_s;
                if (bus.redirect_vld && bus.call) begin
                    replace_s = 1'b1;
                end else begin
                    pop_s = 1'b1;
                end
            end
            SEL_REDIR: begin
                pc_nxt_s = bus.redirect_pc;
                push_s   = bus.call;
            end
            SEL_SEQ:   pc_nxt_s = pc_plus_s;
            default:   pc_nxt_s = pc_plus_s;
        endcase
    end

    // PC and return-miss registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r       <= RESET_VEC;
            ret_miss_r <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            ret_miss_r <= miss_nxt_s;
        end
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .replace (replace_s),
        .din     (pc_plus_s),
        .top     (ras_top_s),
        .cnt     (ras_cnt_s)
    );

    assign bus.pc       = pc_r;
    assign bus.pc_plus  = pc_plus_s;
    assign bus.ras_cnt  = ras_cnt_s;
    assign bus.ret_miss = ret_miss_r;

endmodule
